// File: rtl/alu_wb_stage.sv
// Execute/write-back stage behind the 8-bit ALU: derives carry/borrow, keeps the
// architectural C/Z flags and buffers register-file writes in a 2-entry FIFO.
module alu_wb_stage #(
  parameter int WIDTH = 8,
  parameter int RA_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_we,
  input  logic [RA_W-1:0]  in_rd,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RA_W-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_c,
  output logic             flag_z
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDC = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SUBC = 3'd3;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; the sender holds its payload stable until then, and ready never waits on
  // the far side (in_ready ignores wb_ready).

  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [RA_W-1:0]  r_slot_rd   [2];
  logic [WIDTH-1:0] r_slot_data [2];
  logic             r_flag_c;
  logic             r_flag_z;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_subtrahend;
  logic             w_borrow;
  logic             w_c_next;

  assign in_ready = (r_count < 2'd2) & rst_n;
  assign wb_valid = (r_count != 2'd0);
  assign wb_rd    = r_slot_rd[r_rd_ptr];
  assign wb_data  = r_slot_data[r_rd_ptr];
  assign flag_c   = r_flag_c;
  assign flag_z   = r_flag_z;

  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & in_we;
  assign w_pop    = wb_valid & wb_ready;

  // Carry-in applies only to the chained forms; both compare/add at WIDTH+1 bits.
  assign w_sum        = {1'b0, in_a} + {1'b0, in_b}
                        + {{WIDTH{1'b0}}, (in_opcode == OP_ADDC) & r_flag_c};
  assign w_subtrahend = {1'b0, in_b}
                        + {{WIDTH{1'b0}}, (in_opcode == OP_SUBC) & r_flag_c};
  assign w_borrow     = ({1'b0, in_a} < w_subtrahend);

  always_comb begin
    w_c_next = r_flag_c;
    case (in_opcode)
      OP_ADD, OP_ADDC: w_c_next = w_sum[WIDTH];
      OP_SUB, OP_SUBC: w_c_next = w_borrow;
      default:         w_c_next = r_flag_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (w_accept) begin
      r_flag_c <= w_c_next;
      r_flag_z <= (in_result == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_slot_rd[i]   <= '0;
        r_slot_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_slot_rd[r_wr_ptr]   <= in_rd;
        r_slot_data[r_wr_ptr] <= in_result;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage: a driver issues ALU ops, expected write-backs
// go into a queue and a monitor compares every popped head against it.
module tb_alu_wb_stage;

  localparam int WIDTH = 8;
  localparam int RA_W  = 3;
  localparam int EW    = RA_W + WIDTH;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDC = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SUBC = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_result;
  logic             in_we;
  logic [RA_W-1:0]  in_rd;
  logic             wb_valid;
  logic             wb_ready;
  logic [RA_W-1:0]  wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             flag_c;
  logic             flag_z;

  logic [EW-1:0] exp_q[$];
  int total;
  int bad;

  alu_wb_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_result (in_result),
    .in_we     (in_we),
    .in_rd     (in_rd),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .flag_c    (flag_c),
    .flag_z    (flag_z)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compare the head whenever it is handed to the register file
  always @(negedge clk) begin
    #1;
    if (rst_n && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb", {21'd0, wb_rd, wb_data}, 32'hFFFF_FFFF);
      end else begin
        chk("wb_entry", {21'd0, wb_rd, wb_data}, {21'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] res, input logic we, input logic [2:0] rd);
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_result = res;
    in_we     = we;
    in_rd     = rd;
    in_valid  = 1'b1;
  endtask

  task automatic send(input string name, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] res, input logic we,
                      input logic [2:0] rd, input logic exp_c, input logic exp_z);
    int waited;
    @(negedge clk);
    drive(op, a, b, res, we, rd);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk({name, "_accept_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (we) exp_q.push_back({rd, res});
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk({name, "_flag_c"}, {31'd0, flag_c}, {31'd0, exp_c});
      chk({name, "_flag_z"}, {31'd0, flag_z}, {31'd0, exp_z});
    end
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = 3'd0;
    in_a      = '0;
    in_b      = '0;
    in_result = '0;
    in_we     = 1'b0;
    in_rd     = '0;
    wb_ready  = 1'b1;

    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_flags", {30'd0, flag_c, flag_z}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD carry-out, then one-cycle write-back latency
    send("add_carry", OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 3'd3, 1'b1, 1'b0);
    drain("add_carry");

    // ADD sets C, ADDC consumes it
    send("add_ff", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1);
    send("addc", OP_ADDC, 8'h00, 8'h00, 8'h01, 1'b1, 3'd2, 1'b0, 1'b0);

    // SUB borrow, SUBC consumes it: 5 < 4+1 is false
    send("sub", OP_SUB, 8'h05, 8'h06, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b0);
    send("subc", OP_SUBC, 8'h05, 8'h04, 8'h00, 1'b1, 3'd4, 1'b0, 1'b1);

    // logic op leaves C alone; we=0 op enqueues nothing
    send("sub_set_c", OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b0);
    send("xor_we", OP_XOR, 8'h3C, 8'h3C, 8'h00, 1'b1, 3'd5, 1'b1, 1'b1);
    send("xor_nowe", OP_XOR, 8'h3C, 8'h3C, 8'h00, 1'b0, 3'd5, 1'b1, 1'b1);
    chk("xor_nowe_wb_valid", {31'd0, wb_valid}, 32'd0);
    drain("logic");

    // backpressure: fill both slots, third op must stall
    @(negedge clk);
    wb_ready = 1'b0;
    send("bp_aa", OP_OR, 8'hAA, 8'h00, 8'hAA, 1'b1, 3'd1, 1'b1, 1'b0);
    send("bp_bb", OP_OR, 8'hBB, 8'h00, 8'hBB, 1'b1, 3'd2, 1'b1, 1'b0);
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    drive(OP_SUB, 8'h01, 8'h02, 8'hFF, 1'b1, 3'd4);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_stall_flags", {30'd0, flag_c, flag_z}, 32'd2);
      chk("bp_hold_head", {21'd0, wb_rd, wb_data}, {21'd0, 3'd1, 8'hAA});
    end
    @(negedge clk);
    wb_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    exp_q.push_back({3'd4, 8'hFF});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_third_flags", {30'd0, flag_c, flag_z}, 32'd2);
    drain("bp");

    // asynchronous reset with two entries buffered and C=1
    @(negedge clk);
    wb_ready = 1'b0;
    send("rst_fill0", OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 3'd6, 1'b1, 1'b0);
    send("rst_fill1", OP_OR, 8'h55, 8'h00, 8'h55, 1'b1, 3'd7, 1'b1, 1'b0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("arst_wb_entry", {21'd0, wb_rd, wb_data}, 32'd0);
    chk("arst_flags", {30'd0, flag_c, flag_z}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("after_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Execute/write-back stage directly downstream of the 8-bit ALU.
- Captures each ALU result and derives carry/borrow-out, which the ALU does not produce.
- Maintains the architectural C and Z flag registers. flag_c feeds back to the ALU's carry input.
- Buffers register-file writes in a 2-entry in-order FIFO with valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, datapath width of operands and result
RA_W, 3, register-file address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU op presented this cycle
in_ready  out  1  stage can accept an op
in_opcode  in  3  ALU function: ADD=0, ADDC=1, SUB=2, SUBC=3, AND=4, OR=5, XOR=6, MASK=7
in_a  in  WIDTH  ALU operand 1
in_b  in  WIDTH  ALU operand 2
in_result  in  WIDTH  ALU output for this op
in_we  in  1  op writes a destination register
in_rd  in  RA_W  destination register
wb_valid  out  1  write entry available at FIFO head
wb_ready  in  1  register file consumes the head entry
wb_rd  out  RA_W  head destination register
wb_data  out  WIDTH  head write data
flag_c  out  1  carry/borrow flag register, to ALU C input
flag_z  out  1  zero flag register

Behaviour:
- Reset, asynchronous while rst_n=0:
  - FIFO count=0, wb_valid=0, wb_rd=0, wb_data=0, flag_c=0, flag_z=0.
  - in_ready=0 while rst_n is low.
- Any entries buffered at reset are discarded. No partial write-back is emitted.
- Accept event: in_valid & in_ready at a rising edge.
- Flag update on accept, regardless of in_we:
  - flag_z <= (in_result == 0). Computed locally over all WIDTH bits.
  - ADD: flag_c <= bit WIDTH of the (WIDTH+1)-bit sum in_a+in_b.
  - ADDC: flag_c <= bit WIDTH of in_a+in_b+flag_c, using the pre-update flag_c.
  - SUB: flag_c <= borrow, i.e. in_a < in_b (unsigned).
  - SUBC: flag_c <= (in_a < in_b+flag_c), compared as (WIDTH+1)-bit values.
  - AND/OR/XOR/MASK: flag_c unchanged.
- ALU timing: the ALU sees flag_c combinationally in the cycle it computes. Back-to-back carry-chained ops therefore need no stall, because the flag updates at the accepting edge.
- Enqueue: on accept with in_we=1, push {in_rd, in_result}. Ops with in_we=0 update flags only.
- Dequeue: wb_valid & wb_ready at a rising edge pops the head.
- Handshake signals:
  - wb_valid = (count != 0).
  - in_ready = (count < 2) & rst_n. in_ready does not depend on wb_ready.
- Latency: with the FIFO empty, an op accepted at edge N gives wb_valid=1 with its data from edge N to edge N+1.
- Full: count=2 gives in_ready=0. The upstream holds its op. No overwrite.
- Simultaneous push and pop with count=1: head pops, new entry becomes head next cycle, count stays 1.
- Simultaneous push and pop with count=0: not possible, since wb_valid=0.
- Ordering: strictly FIFO. Implemented as 2 slots with read/write pointers wrapping modulo 2.
- wb_rd/wb_data hold stable while wb_valid=1 and wb_ready=0.
- A pop of an empty FIFO is ignored, since wb_valid=0 gates it.

Test Plan:
- Reset: with rst_n low mid-run (count=2, flag_c=1), all outputs read 0 immediately, without waiting for a clock edge.
- ADD carry: a=0xF0, b=0x20, result=0x10, we=1, rd=3 -> flag_c=1, flag_z=0; next cycle wb_valid=1, wb_rd=3, wb_data=0x10.
- ADDC chain:
  - a=0xFF, b=0x01, result=0x00 -> flag_c=1, flag_z=1.
  - Then ADDC a=0x00, b=0x00, result=0x01 -> flag_c=0, flag_z=0.
- SUB/SUBC borrow: SUB a=0x05, b=0x06, result=0xFF -> flag_c=1. Then SUBC a=0x05, b=0x04 (using flag_c=1), result=0x00 -> flag_c=0, flag_z=1.
- Logic op: with flag_c=1, XOR a=0x3C, b=0x3C, result=0 -> flag_z=1, flag_c stays 1. The same op with we=0 produces no wb_valid.
- Backpressure:
  - Hold wb_ready=0 and push rd=1/0xAA then rd=2/0xBB -> in_ready=0 and the third op stalls with no flag change.
  - Release wb_ready -> outputs 0xAA then 0xBB in order, and in_ready returns to 1 after the first pop.
